// File: rtl/rotate_fb_pkg.sv
// Shared types and helpers for the rotation frame-buffer scheduler.
// Macro ROTATE_FB_TRIPLE_EN selects triple buffering (NBUF=3); otherwise ping-pong (NBUF=2).
package rotate_fb_pkg;

`ifdef ROTATE_FB_TRIPLE_EN
    localparam int NBUF = 3;
`else
    localparam int NBUF = 2;
`endif

    typedef logic [1:0] fb_idx_t;

    // Byte-free base address of a slot: slots are packed back to back in RAM.
    function automatic logic [31:0] fb_base(fb_idx_t idx, int unsigned width, int unsigned height);
        return 32'(idx) * width * height;
    endfunction

endpackage

// File: rtl/rotate_fb_sched_sat_cnt8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module sat_cnt8 (
    input  logic       clk,
    input  logic       srst,
    input  logic       inc,
    output logic [7:0] count
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
endmodule

// File: rtl/rotate_fb_sched.sv
// Frame-buffer slot scheduler between the rotated-pixel writer and the scan-out reader.
// ROTATE_FB_TRIPLE_EN enables tear-free triple buffering; undefined gives legacy ping-pong.
module rotate_fb_sched
    import rotate_fb_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int AW     = 18
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          wr_vblank,
    input  logic          rd_start,
    output logic [1:0]    wr_idx,
    output logic [1:0]    rd_idx,
    output logic [AW-1:0] wr_base,
    output logic [AW-1:0] rd_base,
    output logic          wr_swap,
    output logic          rd_valid,
    output logic [7:0]    drop_cnt,
    output logic [7:0]    repeat_cnt
);
    fb_idx_t       wr_idx_q, wr_idx_d;
    fb_idx_t       rd_idx_q, rd_idx_d;
    fb_idx_t       pend_idx_q, pend_idx_d;
    logic          pend_valid_q, pend_valid_d;
    logic          old_vblank_q, old_vblank_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_swap_q, wr_swap_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic          wr_done;
    logic          drop_inc;
    logic          repeat_inc;
    fb_idx_t       next_wr;

    always_comb begin
        wr_done      = wr_vblank & ~old_vblank_q;
        old_vblank_d = wr_vblank;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        pend_idx_d   = pend_idx_q;
        pend_valid_d = pend_valid_q;
        rd_valid_d   = rd_valid_q;
        wr_swap_d    = 1'b0;
        drop_inc     = 1'b0;
        repeat_inc   = 1'b0;

`ifdef ROTATE_FB_TRIPLE_EN
        // The slot held by neither side; with pend_valid set it is the pending frame.
        next_wr = 2'd3 - wr_idx_q - rd_idx_q;
`else
        next_wr = wr_idx_q ^ 2'd1;
`endif

        // The write is resolved first so a same-cycle read picks up the fresh frame.
        if (wr_done) begin
            drop_inc     = pend_valid_q;
            pend_idx_d   = wr_idx_q;
            pend_valid_d = 1'b1;
            wr_idx_d     = next_wr;
            wr_swap_d    = 1'b1;
        end

        if (rd_start) begin
            if (pend_valid_d) begin
                rd_idx_d     = pend_idx_d;
                pend_valid_d = 1'b0;
                rd_valid_d   = 1'b1;
            end else begin
                repeat_inc = 1'b1;
            end
        end

        wr_base_d = AW'(fb_base(wr_idx_d, WIDTH, HEIGHT));
        rd_base_d = AW'(fb_base(rd_idx_d, WIDTH, HEIGHT));
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_idx_q     <= 2'd0;
            rd_idx_q     <= 2'd1;
            pend_idx_q   <= 2'd2;
            pend_valid_q <= 1'b0;
            old_vblank_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            wr_swap_q    <= 1'b0;
            wr_base_q    <= '0;
            rd_base_q    <= AW'(fb_base(2'd1, WIDTH, HEIGHT));
        end else begin
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            pend_idx_q   <= pend_idx_d;
            pend_valid_q <= pend_valid_d;
            old_vblank_q <= old_vblank_d;
            rd_valid_q   <= rd_valid_d;
            wr_swap_q    <= wr_swap_d;
            wr_base_q    <= wr_base_d;
            rd_base_q    <= rd_base_d;
        end
    end

    logic [1:0] cnt_inc;
    logic [7:0] cnt_val [2];

    assign cnt_inc = {repeat_inc, drop_inc};

    // Index 0 counts dropped frames, index 1 counts repeated frames.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_cnt8 u_cnt (
                .clk   (clk_sys),
                .srst  (reset),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign wr_idx     = wr_idx_q;
    assign rd_idx     = rd_idx_q;
    assign wr_base    = wr_base_q;
    assign rd_base    = rd_base_q;
    assign wr_swap    = wr_swap_q;
    assign rd_valid   = rd_valid_q;
    assign drop_cnt   = cnt_val[0];
    assign repeat_cnt = cnt_val[1];
endmodule

// File: tb/tb_rotate_fb_sched.sv
// Self-checking bench for rotate_fb_sched against a frame-level reference model.
// Follows ROTATE_FB_TRIPLE_EN like the design does.
module tb_rotate_fb_sched;
    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;
    localparam int AW     = 18;
    localparam int FRAME  = WIDTH * HEIGHT;
`ifdef ROTATE_FB_TRIPLE_EN
    localparam bit TRIPLE = 1'b1;
`else
    localparam bit TRIPLE = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          wr_vblank = 1'b0;
    logic          rd_start = 1'b0;
    logic [1:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic [AW-1:0] wr_base;
    logic [AW-1:0] rd_base;
    logic          wr_swap;
    logic          rd_valid;
    logic [7:0]    drop_cnt;
    logic [7:0]    repeat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: slot numbers and frame bookkeeping as plain integers.
    int m_wr, m_rd, m_pend, m_pv, m_rdv, m_drop, m_rep, m_swap, m_old;

    rotate_fb_sched #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .wr_vblank  (wr_vblank),
        .rd_start   (rd_start),
        .wr_idx     (wr_idx),
        .rd_idx     (rd_idx),
        .wr_base    (wr_base),
        .rd_base    (rd_base),
        .wr_swap    (wr_swap),
        .rd_valid   (rd_valid),
        .drop_cnt   (drop_cnt),
        .repeat_cnt (repeat_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic model_reset();
        m_wr = 0; m_rd = 1; m_pend = 2; m_pv = 0; m_rdv = 0;
        m_drop = 0; m_rep = 0; m_swap = 0; m_old = 1;
    endtask

    task automatic model_step(input logic vb, input logic st);
        int done;
        int spare;
        done  = (vb && !m_old) ? 1 : 0;
        m_old = vb ? 1 : 0;
        m_swap = done;
        if (done != 0) begin
            if (m_pv != 0 && m_drop < 255) m_drop++;
            spare = 0;
            if (TRIPLE) begin
                for (int s = 0; s < 3; s++) if (s != m_wr && s != m_rd) spare = s;
            end else begin
                spare = 1 - m_wr;
            end
            m_pend = m_wr;
            m_wr   = spare;
            m_pv   = 1;
        end
        if (st) begin
            if (m_pv != 0) begin
                m_rd = m_pend; m_pv = 0; m_rdv = 1;
            end else if (m_rep < 255) begin
                m_rep++;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic vb, input logic st);
        reset = r; wr_vblank = vb; rd_start = st;
        @(posedge clk_sys);
        if (r) model_reset();
        else model_step(vb, st);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++; if (wr_idx !== 2'd0) begin n_fail++; $display("FAIL reset_wr_idx got=%0d exp=0", wr_idx); end
        n_checks++; if (rd_idx !== 2'd1) begin n_fail++; $display("FAIL reset_rd_idx got=%0d exp=1", rd_idx); end
        n_checks++; if (wr_base !== AW'(0)) begin n_fail++; $display("FAIL reset_wr_base got=%0d exp=0", wr_base); end
        n_checks++; if (rd_base !== AW'(FRAME)) begin n_fail++; $display("FAIL reset_rd_base got=%0d exp=%0d", rd_base, FRAME); end
        n_checks++; if ({wr_swap, rd_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {wr_swap, rd_valid}); end
        n_checks++; if ({drop_cnt, repeat_cnt} !== 16'd0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", drop_cnt, repeat_cnt); end
    endtask

    task automatic test_first_frame();
        int exp_wr;
        exp_wr = TRIPLE ? 2 : 1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++; if (wr_idx !== 2'(exp_wr)) begin n_fail++; $display("FAIL first_wr_idx got=%0d exp=%0d", wr_idx, exp_wr); end
        n_checks++; if (wr_base !== AW'(exp_wr * FRAME)) begin n_fail++; $display("FAIL first_wr_base got=%0d exp=%0d", wr_base, exp_wr * FRAME); end
        n_checks++; if (wr_swap !== 1'b1) begin n_fail++; $display("FAIL first_wr_swap got=%b exp=1", wr_swap); end
        n_checks++; if (rd_idx !== 2'd1) begin n_fail++; $display("FAIL first_rd_idx got=%0d exp=1", rd_idx); end
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++; if (wr_swap !== 1'b0) begin n_fail++; $display("FAIL first_swap_pulse got=%b exp=0", wr_swap); end
    endtask

    task automatic test_read();
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++; if (rd_idx !== 2'd0) begin n_fail++; $display("FAIL read_rd_idx got=%0d exp=0", rd_idx); end
        n_checks++; if (rd_base !== AW'(0)) begin n_fail++; $display("FAIL read_rd_base got=%0d exp=0", rd_base); end
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL read_rd_valid got=%b exp=1", rd_valid); end
        n_checks++; if (repeat_cnt !== 8'd0) begin n_fail++; $display("FAIL read_repeat got=%0d exp=0", repeat_cnt); end
        n_checks++; if (wr_idx !== 2'(m_wr)) begin n_fail++; $display("FAIL read_wr_idx got=%0d exp=%0d", wr_idx, m_wr); end
    endtask

    task automatic test_drop();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
        n_checks++; if (wr_idx !== 2'(m_wr)) begin n_fail++; $display("FAIL drop_wr_idx got=%0d exp=%0d", wr_idx, m_wr); end
    endtask

    task automatic test_simultaneous();
        int old_wr;
        cycle(1'b0, 1'b0, 1'b0);
        old_wr = m_wr;
        cycle(1'b0, 1'b1, 1'b1);
        n_checks++; if (rd_idx !== 2'(old_wr)) begin n_fail++; $display("FAIL simul_rd_idx got=%0d exp=%0d", rd_idx, old_wr); end
        n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL simul_drop got=%0d exp=2", drop_cnt); end
        n_checks++; if (wr_swap !== 1'b1) begin n_fail++; $display("FAIL simul_swap got=%b exp=1", wr_swap); end
        n_checks++; if (wr_idx !== 2'(m_wr)) begin n_fail++; $display("FAIL simul_wr_idx got=%0d exp=%0d", wr_idx, m_wr); end
        // Pending was consumed, so the next read is a repeat.
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++; if (repeat_cnt !== 8'd1) begin n_fail++; $display("FAIL simul_pend_clear got=%0d exp=1", repeat_cnt); end
    endtask

    task automatic test_repeat_sat();
        int exp_rd;
        exp_rd = m_rd;
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b1);
        n_checks++; if (repeat_cnt !== 8'd255) begin n_fail++; $display("FAIL repeat_sat got=%0d exp=255", repeat_cnt); end
        n_checks++; if (rd_idx !== 2'(exp_rd)) begin n_fail++; $display("FAIL repeat_rd_idx got=%0d exp=%0d", rd_idx, exp_rd); end
    endtask

    task automatic test_reset_vblank_high();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        n_checks++; if ({drop_cnt, repeat_cnt} !== 16'd0) begin n_fail++; $display("FAIL rst_mid_counts got=%0d/%0d exp=0/0", drop_cnt, repeat_cnt); end
        n_checks++; if ({wr_idx, rd_idx, rd_valid} !== 5'b00_01_0) begin n_fail++; $display("FAIL rst_mid_state got=%0d/%0d/%b exp=0/1/0", wr_idx, rd_idx, rd_valid); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            n_checks++; if (wr_swap !== 1'b0) begin n_fail++; $display("FAIL vb_held_swap cycle=%0d got=%b exp=0", i, wr_swap); end
        end
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        n_checks++; if (wr_swap !== 1'b1) begin n_fail++; $display("FAIL vb_rise_swap got=%b exp=1", wr_swap); end
    endtask

    task automatic test_random();
        logic vb, st;
        vb = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 0) vb = ~vb;
            st = ($urandom_range(0, 2) == 0);
            cycle(1'b0, vb, st);
            n_checks++; if (wr_idx !== 2'(m_wr)) begin n_fail++; $display("FAIL rnd_wr_idx i=%0d got=%0d exp=%0d", i, wr_idx, m_wr); end
            n_checks++; if (rd_idx !== 2'(m_rd)) begin n_fail++; $display("FAIL rnd_rd_idx i=%0d got=%0d exp=%0d", i, rd_idx, m_rd); end
            n_checks++; if (wr_base !== AW'(m_wr * FRAME)) begin n_fail++; $display("FAIL rnd_wr_base i=%0d got=%0d exp=%0d", i, wr_base, m_wr * FRAME); end
            n_checks++; if (rd_base !== AW'(m_rd * FRAME)) begin n_fail++; $display("FAIL rnd_rd_base i=%0d got=%0d exp=%0d", i, rd_base, m_rd * FRAME); end
            n_checks++; if (wr_swap !== 1'(m_swap)) begin n_fail++; $display("FAIL rnd_wr_swap i=%0d got=%b exp=%0d", i, wr_swap, m_swap); end
            n_checks++; if (rd_valid !== 1'(m_rdv)) begin n_fail++; $display("FAIL rnd_rd_valid i=%0d got=%b exp=%0d", i, rd_valid, m_rdv); end
            n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop i=%0d got=%0d exp=%0d", i, drop_cnt, m_drop); end
            n_checks++; if (repeat_cnt !== 8'(m_rep)) begin n_fail++; $display("FAIL rnd_repeat i=%0d got=%0d exp=%0d", i, repeat_cnt, m_rep); end
            if (TRIPLE) begin
                n_checks++; if (wr_idx === rd_idx) begin n_fail++; $display("FAIL rnd_distinct i=%0d wr=%0d rd=%0d exp=different", i, wr_idx, rd_idx); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_read();
        test_drop();
        test_simultaneous();
        test_repeat_sat();
        test_reset_vblank_high();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rotate_fb_sched.md
# rotate_fb_sched

Frame-buffer scheduler for the 90° rotation path. It decides which frame-buffer slot the rotated-pixel writer fills and which slot the scan-out reader drains, and it drives the base addresses for both sides. It replaces hard ping-pong on vblank with tear-free triple buffering, and it counts dropped and repeated frames. It sits between the writer's blanking logic and the reader's frame-start logic, ahead of the frame-buffer RAM address adders.

## Interface
Parameters:
- WIDTH, 320, source line length in pixels
- HEIGHT, 240, source line count
- AW, 18, RAM address width; must hold NBUF*WIDTH*HEIGHT

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- wr_vblank  in  1  writer vblank, already in clk_sys domain; rising edge = writer frame complete
- rd_start  in  1  one-cycle pulse; reader is starting a new output frame
- wr_idx  out  2  slot the writer fills
- rd_idx  out  2  slot the reader drains
- wr_base  out  AW  wr_idx*WIDTH*HEIGHT
- rd_base  out  AW  rd_idx*WIDTH*HEIGHT
- wr_swap  out  1  one-cycle pulse when wr_idx changed this cycle
- rd_valid  out  1  reader holds a completed frame; sticky until reset
- drop_cnt  out  8  frames completed but never read; saturates at 255
- repeat_cnt  out  8  rd_start pulses with no new frame; saturates at 255

## Operation
- Internal state: wr_idx, rd_idx, pend_idx, pend_valid, old_vblank.
- wr_done = wr_vblank & ~old_vblank.
- Triple mode (NBUF=3):
  - third = 3 - wr_idx - rd_idx, computed from the current register values.
  - The three slots (wr, rd, third) are always distinct.
- wr_done only:
  - pend_idx <= wr_idx; pend_valid <= 1; wr_idx <= third; wr_swap <= 1.
  - If pend_valid was already 1, drop_cnt increments.
- rd_start only:
  - If pend_valid: rd_idx <= pend_idx; pend_valid <= 0; rd_valid <= 1.
  - Otherwise rd_idx holds and repeat_cnt increments.
- wr_done and rd_start in the same cycle:
  - The write completes first, then the read takes the just-completed frame.
  - rd_idx <= old wr_idx; wr_idx <= third; pend_valid <= 0; rd_valid <= 1; wr_swap <= 1.
  - drop_cnt increments if pend_valid was 1 (the old pending slot becomes the writer's slot).
- Invariant: wr_idx != rd_idx at all times, so the reader never sees a partially written frame.
- Counters saturate at 255 and never wrap.

## Timing
- Reset values: wr_idx=0, rd_idx=1, pend_idx=2, pend_valid=0, rd_valid=0, wr_swap=0, drop_cnt=0, repeat_cnt=0, wr_base=0, rd_base=WIDTH*HEIGHT, old_vblank=1.
- Because old_vblank resets to 1, wr_vblank held high through reset release is not a frame end; it must fall and rise again.
- wr_vblank first sampled high at edge N (having been low at N-1) → new wr_idx, wr_base and wr_swap valid after edge N.
- rd_start sampled high at edge N → rd_idx, rd_base valid after edge N; the reader latches rd_base on the next cycle.
- wr_base and rd_base are registered and updated on the same edge as their index; no combinational path from inputs to outputs.
- wr_swap is high for exactly one cycle per wr_done.
- Reset asserted mid-frame: all state returns to reset values on that edge. In-flight frames are discarded and not counted.

## Configuration
- ROTATE_FB_TRIPLE_EN defined: NBUF=3, triple-buffer behaviour as above.
- ROTATE_FB_TRIPLE_EN undefined: NBUF=2, legacy ping-pong:
  - wr_done toggles wr_idx, sets pend_valid, pulses wr_swap; drop_cnt increments if pend_valid was already 1.
  - rd_start sets rd_idx <= ~wr_idx (the last completed slot; old wr_idx if simultaneous with wr_done), clears pend_valid, sets rd_valid. With no pending frame, repeat_cnt increments and rd_idx holds.
  - Tearing is possible in this mode and is accepted.
  - Reset: wr_idx=0, rd_idx=1.
- AW must cover NBUF*WIDTH*HEIGHT in both modes.

## Structure
- Package rotate_fb_pkg holds:
  - NBUF (selected by the macro)
  - typedef fb_idx_t (2 bits)
  - function fb_base(idx, WIDTH, HEIGHT)
- Sub-module sat_cnt8: 8-bit saturating increment counter with synchronous reset. It is instantiated twice, for drop_cnt and repeat_cnt.
- The next-index logic stays in the top module.

## Test plan
- Triple mode, WIDTH=320, HEIGHT=240; reset, then one wr_done → wr_idx=2, wr_base=153600, pend_valid=1, wr_swap high one cycle; rd_idx=1.
- After the previous step, rd_start → rd_idx=0, rd_base=0, rd_valid=1; repeat_cnt=0.
- Two wr_done with no rd_start → drop_cnt=1; wr_idx never equals rd_idx across 1000 random wr_done/rd_start cycles.
- wr_done and rd_start in the same cycle with pend_valid=1 → rd_idx=old wr_idx, pend_valid=0, drop_cnt +1.
- 300 rd_start pulses with no wr_done → repeat_cnt=255 (saturated), rd_idx unchanged.
- Reset asserted with wr_vblank held high → no wr_swap until wr_vblank falls and rises. Ping-pong build: wr_done then rd_start → wr_idx=1, rd_idx=0.
